// File: rtl/ball_pkg.sv
// Shared definitions for the ball2004 checker datapath: operand width,
// run-counter width and the operand loader state encoding.
package ball_pkg;

   localparam int W     = 3;
   localparam int CNT_W = 8;

   typedef enum logic [3:0] {
      LOAD_X = 4'b0001,
      LOAD_Y = 4'b0010,
      LOAD_Z = 4'b0100,
      HOLD   = 4'b1000
   } state_e;

endpackage

// File: rtl/ball_operand_loader.sv
// Collects X, Y, Z over valid/ready and holds them frozen until ops_ack; ops_valid 1 cycle after the Z transfer.
// in_ready is low while a set is held, and also for the first cycle out of reset.
module ball_operand_loader #(
   parameter int W     = ball_pkg::W,
   parameter int CNT_W = ball_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             flush,
   output logic             ops_valid,
   output logic [W-1:0]     x,
   output logic [W-1:0]     y,
   output logic [W-1:0]     z,
   output logic             ops_ordered,
   input  logic             ops_ack,
   output logic [CNT_W-1:0] run_count,
   output logic             err
);

   import ball_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
   logic             ops_valid_q, ops_valid_d;
   logic             ops_ordered_q, ops_ordered_d;
   logic [CNT_W-1:0] run_count_q, run_count_d;
   logic             err_q, err_d;
   logic             live_q, live_d;
   logic             xfer;

   // live_q keeps in_ready low for the cycle in which reset is applied.
   assign in_ready = live_q && (state_q != HOLD);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      z_d           = z_q;
      ops_valid_d   = ops_valid_q;
      ops_ordered_d = ops_ordered_q;
      run_count_d   = run_count_q;
      err_d         = err_q;
      live_d        = 1'b1;

      if (flush) begin
         state_d     = LOAD_X;
         ops_valid_d = 1'b0;
      end else begin
         if (ops_ack && (state_q != HOLD)) begin
            err_d = 1'b1;
         end
         case (state_q)
            LOAD_X: if (xfer) begin
               x_d     = in_data;
               state_d = LOAD_Y;
            end
            LOAD_Y: if (xfer) begin
               y_d     = in_data;
               state_d = LOAD_Z;
            end
            LOAD_Z: if (xfer) begin
               z_d           = in_data;
               ops_ordered_d = (x_q < y_q) && (y_q < in_data);
               ops_valid_d   = 1'b1;
               state_d       = HOLD;
            end
            HOLD: if (ops_ack) begin
               ops_valid_d = 1'b0;
               state_d     = LOAD_X;
               if (run_count_q != CNT_MAX) begin
                  run_count_d = run_count_q + CNT_ONE;
               end
            end
            default: state_d = LOAD_X;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= LOAD_X;
         x_q           <= '0;
         y_q           <= '0;
         z_q           <= '0;
         ops_valid_q   <= 1'b0;
         ops_ordered_q <= 1'b0;
         run_count_q   <= '0;
         err_q         <= 1'b0;
         live_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         z_q           <= z_d;
         ops_valid_q   <= ops_valid_d;
         ops_ordered_q <= ops_ordered_d;
         run_count_q   <= run_count_d;
         err_q         <= err_d;
         live_q        <= live_d;
      end
   end

   assign ops_valid   = ops_valid_q;
   assign x           = x_q;
   assign y           = y_q;
   assign z           = z_q;
   assign ops_ordered = ops_ordered_q;
   assign run_count   = run_count_q;
   assign err         = err_q;

   // The checker samples x/y/z over several cycles, so a held set must not move.
   a_ops_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (ops_valid_q && $past(ops_valid_q)) |->
         (x_q == $past(x_q) && y_q == $past(y_q) && z_q == $past(z_q) &&
          ops_ordered_q == $past(ops_ordered_q)));

endmodule

// File: doc/ball_operand_loader.md
Name: ball_operand_loader

Overview:
- Upstream stage of the ball2004 comparison checker; supplies its X/Y/Z operands.
- Accepts three W-bit operands over a valid/ready stream, in fixed order X, Y, Z.
- Presents them as a frozen, registered operand set until the downstream checker acknowledges completion.
- Keeps a saturating completed-run counter and a sticky protocol-error flag, and carries a stability assertion.

Parameters:
- W, 3, operand width in bits.
- CNT_W, 8, width of the completed-run counter.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  upstream has an operand word on in_data.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  W  operand word.
- flush  input  1  synchronous abort: discard partial or held set.
- ops_valid  output  1  x/y/z hold a complete, stable set.
- x  output  W  operand X.
- y  output  W  operand Y.
- z  output  W  operand Z.
- ops_ordered  output  1  registered (x<y)&&(y<z), unsigned; valid while ops_valid.
- ops_ack  input  1  downstream has finished with the current set.
- run_count  output  CNT_W  number of acknowledged sets, saturating.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state <= LOAD_X; x, y, z <= 0; ops_valid, ops_ordered, err <= 0; run_count <= 0.
  - in_ready is 0 during the reset cycle and 1 from the first cycle after.
- States and transitions:
  - LOAD_X, LOAD_Y, LOAD_Z, HOLD; one-hot encoding.
  - in_ready = 1 exactly in the LOAD_* states (Moore, from the state register).
  - A transfer is in_valid && in_ready at posedge.
  - LOAD_X transfer: x <= in_data, go to LOAD_Y. LOAD_Y transfer: y <= in_data, go to LOAD_Z.
  - LOAD_Z transfer: z <= in_data; ops_ordered <= (x<y)&&(y<in_data); ops_valid <= 1; go to HOLD.
  - Without a transfer the state holds. in_data is don't-care when in_valid=0.
- Latency: ops_valid rises in the cycle after the Z transfer. Minimum 3 cycles from the first X transfer to ops_valid=1.
- HOLD:
  - in_ready=0; x, y, z and ops_ordered are frozen.
  - On ops_ack: ops_valid <= 0, run_count <= run_count+1, saturating at 2^CNT_W-1 (never wraps), state <= LOAD_X.
  - ops_valid drops the cycle after ack. x/y/z keep their stale values until overwritten by the next load.
  - Back-to-back: the next X may transfer in the first cycle after the ack cycle.
- ops_ack outside HOLD: ignored for state and count; err <= 1 and stays set until reset.
- flush, taken in any state:
  - state <= LOAD_X; ops_valid <= 0; the partial set is discarded; x/y/z are not cleared.
  - flush has priority over a same-cycle transfer (the word is not consumed; in_ready stays 1 but the word is dropped) and over a same-cycle ack.
  - flush with ack in HOLD: no count increment, no err.
- Reset mid-operation: any partial or held set is lost and run_count clears. No output glitches, since all outputs are registered.
- Property (asserted in-module): if ops_valid was 1 in the previous cycle and is still 1, then x, y, z and ops_ordered equal their previous values.
- Width rules: all comparisons are unsigned W-bit. run_count increments only in HOLD with ack and !flush.

Decomposition:
- Shared package ball_pkg holds: localparam W (shared with the checker), the state encodings LOAD_X/LOAD_Y/LOAD_Z/HOLD, and CNT_W.
- No sub-module: a single FSM plus registers.
- The instantiating top wires x/y/z to the checker's X/Y/Z and drives ops_ack from the checker's L3||L4.

Test Plan:
- Load 1, 2, 3 with in_valid held high → in_ready 1,1,1,0; ops_valid=1 three cycles after the first transfer; x=1, y=2, z=3, ops_ordered=1.
- Load 5, 2, 7, then toggle in_valid in HOLD → in_ready=0, x/y/z unchanged, ops_ordered=0; ack → ops_valid=0 next cycle, run_count=1.
- Load X=4, Y=6, then assert flush in the same cycle as a Z transfer → state LOAD_X, ops_valid stays 0; the next load of 0, 1, 2 yields x=0, y=1, z=2.
- Pulse ops_ack in LOAD_Y → err=1, state and run_count unchanged; err stays 1 through later normal runs until rst_n=0.
- With CNT_W=2, complete 5 acked runs → run_count reads 1, 2, 3, 3, 3; flush+ack in HOLD → count unchanged.
- Drop rst_n while in HOLD with x=7 → the next cycle shows all outputs 0 and in_ready=0; the following cycle shows in_ready=1.
